// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit timing both ends must agree on.
package uart_pkg;

    localparam int CLKS_PER_BIT = 16;
    localparam int DATA_BITS    = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Start bit is checked half a bit in, so later samples land mid-bit.
    function automatic int half_bit(input int clks);
        return clks / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling from a per-bit counter, framing-error
// detection, and a BREAK state so a held-low line cannot retrigger a frame.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | half-bit wait, confirms the start bit is still low
// DATA  | sample eight data bits, LSB first, one per bit period
// STOP  | sample the stop bit; high delivers the byte, low is a framing error
// BREAK | after a framing error, wait for the line to return high
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Rx,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       RxErr,
    output logic       RxBusy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shift;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (Rx),
        .q     (rx_s)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bitn   <= '0;
            shift  <= '0;
            RxData <= '0;
            RxDone <= 1'b0;
            RxErr  <= 1'b0;
            RxBusy <= 1'b0;
        end else begin
            RxDone <= 1'b0;
            RxErr  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state  <= ST_START;
                        cnt    <= '0;
                        RxBusy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= ST_DATA;
                            bitn  <= '0;
                        end else begin
                            state  <= ST_IDLE;
                            RxBusy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == FULL_M1) begin
                        shift[bitn] <= rx_s;
                        cnt         <= '0;
                        bitn        <= bitn + 3'd1;
                        if (bitn == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            RxData <= shift;
                            RxDone <= 1'b1;
                            state  <= ST_IDLE;
                            RxBusy <= 1'b0;
                        end else begin
                            RxErr <= 1'b1;
                            state <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state  <= ST_IDLE;
                        RxBusy <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    RxBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with an event-queue model of when each
// frame must complete and what the held byte must be.
module tb_uart_receiver;

    localparam int C   = 16;
    localparam int H   = C / 2;
    // Stop bit is sampled at edge 3+H+9C; counting edge 1 as offset 0.
    localparam int LAT = 2 + H + 9 * C;

    typedef struct {
        int         cyc;
        bit         is_done;
        logic [7:0] data;
    } ev_t;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Rx = 1'b1;
    logic [7:0] RxData;
    logic       RxDone;
    logic       RxErr;
    logic       RxBusy;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         checking = 1'b0;

    ev_t        evq[$];
    logic [7:0] model_data = 8'h00;
    int         done_count = 0;
    int         err_count = 0;
    int         done_cycs[$];
    int         last_err_cyc = 0;
    logic [7:0] got[$];
    int         busy_rise = 0;
    int         busy_fall = 0;
    logic       busy_prev = 1'b0;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Rx     (Rx),
        .RxData (RxData),
        .RxDone (RxDone),
        .RxErr  (RxErr),
        .RxBusy (RxBusy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (checking) begin
            logic exp_done;
            logic exp_err;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                exp_done = evq[0].is_done;
                exp_err  = !evq[0].is_done;
                if (evq[0].is_done) model_data = evq[0].data;
                void'(evq.pop_front());
            end
            chk("rx_done", {31'd0, RxDone}, {31'd0, exp_done});
            chk("rx_err", {31'd0, RxErr}, {31'd0, exp_err});
            chk("rx_data", {24'd0, RxData}, {24'd0, model_data});
            if (RxDone === 1'b1) begin
                done_count++;
                done_cycs.push_back(cyc);
                got.push_back(RxData);
            end
            if (RxErr === 1'b1) begin
                err_count++;
                last_err_cyc = cyc;
            end
            if (RxBusy === 1'b1 && !busy_prev) busy_rise = cyc;
            if (RxBusy === 1'b0 && busy_prev) busy_fall = cyc;
            busy_prev = RxBusy;
        end
    end

    // Drives one 8N1 frame; abort_at >= 0 asserts reset at that cycle of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int abort_at, output int e1);
        logic [9:0] bits;
        bits = {stop_val, b, 1'b0};
        e1 = 0;
        for (int t = 0; t < 10 * C; t++) begin
            @(posedge Clk);
            #1;
            if (t == 0) begin
                e1 = cyc + 1;
                if (abort_at < 0) evq.push_back('{e1 + LAT, stop_val, b});
            end
            if (t == abort_at) begin
                Rst_n = 1'b0;
                Rx = 1'b1;
                evq.delete();
                model_data = 8'h00;
                break;
            end
            Rx = bits[t / C];
        end
    endtask

    initial begin
        int e1;
        int g1;
        logic [7:0] lb[6];
        lb = '{8'd21, 8'd5, 8'd8, 8'd6, 8'd9, 8'd10};

        repeat (3) @(posedge Clk);
        #1;
        chk("reset_done", {31'd0, RxDone}, 32'd0);
        chk("reset_err", {31'd0, RxErr}, 32'd0);
        chk("reset_busy", {31'd0, RxBusy}, 32'd0);
        chk("reset_data", {24'd0, RxData}, 32'h00);
        Rst_n = 1'b1;
        checking = 1'b1;
        repeat (5) @(posedge Clk);

        send_frame(8'h15, 1'b1, -1, e1);
        repeat (2 * C) @(posedge Clk);
        #1;
        chk("f15_count", done_count, 1);
        chk("f15_err", err_count, 0);
        chk("f15_data", {24'd0, RxData}, 32'h15);
        chk("f15_done_edge", done_cycs[0] - e1, 154);
        chk("f15_busy_rise", busy_rise - e1, 2);
        chk("f15_busy_fall", busy_fall - e1, 154);

        send_frame(8'h05, 1'b1, -1, e1);
        send_frame(8'h08, 1'b1, -1, e1);
        send_frame(8'h06, 1'b1, -1, e1);
        repeat (2 * C) @(posedge Clk);
        #1;
        chk("b2b_count", done_count, 4);
        chk("b2b_gap1", done_cycs[2] - done_cycs[1], 160);
        chk("b2b_gap2", done_cycs[3] - done_cycs[2], 160);
        chk("b2b_order", {got[1], got[2], got[3]}, 32'h050806);

        @(posedge Clk);
        #1;
        g1 = cyc + 1;
        Rx = 1'b0;
        repeat (C / 4) @(posedge Clk);
        #1;
        Rx = 1'b1;
        repeat (2 * C) @(posedge Clk);
        #1;
        chk("glitch_count", done_count, 4);
        chk("glitch_err", err_count, 0);
        chk("glitch_data", {24'd0, RxData}, 32'h06);
        chk("glitch_busy_rise", busy_rise - g1, 2);
        chk("glitch_busy_len", busy_fall - busy_rise, 8);

        send_frame(8'h09, 1'b0, -1, e1);
        repeat (3 * C) @(posedge Clk);
        #1;
        chk("ferr_count", err_count, 1);
        chk("ferr_edge", last_err_cyc - e1, 154);
        chk("ferr_done", done_count, 4);
        chk("ferr_data", {24'd0, RxData}, 32'h06);
        chk("ferr_break_busy", {31'd0, RxBusy}, 32'd1);
        Rx = 1'b1;
        repeat (C) @(posedge Clk);
        #1;
        chk("ferr_idle_busy", {31'd0, RxBusy}, 32'd0);
        send_frame(8'h0A, 1'b1, -1, e1);
        repeat (2 * C) @(posedge Clk);
        #1;
        chk("f0a_count", done_count, 5);
        chk("f0a_data", {24'd0, RxData}, 32'h0A);

        send_frame(8'hA5, 1'b1, 5 * C + H, e1);
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", {31'd0, RxBusy}, 32'd0);
        chk("rst_data", {24'd0, RxData}, 32'h00);
        chk("rst_count", done_count, 5);
        Rst_n = 1'b1;
        repeat (2 * C) @(posedge Clk);
        send_frame(8'h3C, 1'b1, -1, e1);
        repeat (2 * C) @(posedge Clk);
        #1;
        chk("f3c_count", done_count, 6);
        chk("f3c_data", {24'd0, RxData}, 32'h3C);

        foreach (lb[i]) send_frame(lb[i], 1'b1, -1, e1);
        repeat (2 * C) @(posedge Clk);
        #1;
        chk("loop_count", done_count, 12);
        foreach (lb[i]) chk("loop_byte", {24'd0, got[6 + i]}, {24'd0, lb[i]});
        chk("loop_last", {24'd0, RxData}, 32'd10);
        chk("final_err", err_count, 1);
        chk("final_pending", evq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
